ahb_line_fill_master: RTL and testbench

- Responder for the I-cache miss interface: accepts a line-fill request (mem_req/mem_addr) and returns a full cache line (mem_data_out, mem_ready pulse).
- Fetches the line as an AHB-Lite INCR4 read burst of 32-bit beats, assembling beats into one CACHE_LINE-wide word.
- Sits between the I-cache refill port and the AHB bus; read-only, one outstanding fill.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/line_assembler.sv | 45 ++++
 rtl/ahb_line_fill_master.sv | 142 ++++++++++++++
 tb/tb_ahb_line_fill_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite definitions shared by the I-cache line-fill master.
// Holds the HTRANS encoding, the fixed control constants driven for every
// instruction fetch, and the fill FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD   = 3'b010;
    localparam logic [2:0] HBURST_INCR4 = 3'b011;
    localparam logic [3:0] HPROT_IFETCH = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DONE,
        ST_ERR
    } fill_state_t;

endpackage

// File: rtl/line_assembler.sv
// Collects 32-bit AHB read beats into one cache line.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears line and counter)
//   clear     - rewind the beat counter at the start of a fill
//   capture   - write word into the slot selected by the beat counter
//   word      - incoming beat (hrdata)
//   line      - assembled line
//   done      - high in the cycle the last beat is captured
module line_assembler #(
    parameter int CACHE_LINE = 128,
    parameter int BEATS      = CACHE_LINE / 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [31:0]           word,
    output logic [CACHE_LINE-1:0] line,
    output logic                  done
);
    localparam int IDXW = $clog2(BEATS);

    logic [IDXW-1:0] beat_idx;

    // clear only rewinds the counter: the previous line stays visible to the
    // cache until the first beat of the next fill overwrites slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            line     <= '0;
            beat_idx <= '0;
        end else if (clear) begin
            beat_idx <= '0;
        end else if (capture) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_idx == IDXW'(i)) begin
                    line[32*i +: 32] <= word;
                end
            end
            beat_idx <= beat_idx + IDXW'(1);
        end
    end

    assign done = capture && (beat_idx == IDXW'(BEATS - 1));

endmodule

// File: rtl/ahb_line_fill_master.sv
// I-cache line-fill responder: fetches one line as an AHB-Lite INCR4 read
// burst and hands it back to the cache with a one-cycle mem_ready pulse.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mem_req, mem_addr   - fill request (level) and miss address from the cache
//   mem_data_out        - assembled line
//   mem_ready, mem_err  - completion pulse and bus-error flag
//   haddr..hprot        - AHB address/control (registered)
//   hrdata, hready, hresp - AHB read data and response
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no fill in flight, sampling mem_req
// ST_BURST | INCR4 in progress (address and data phases overlapping)
// ST_DONE  | mem_ready pulse cycle
// ST_ERR   | first ERROR cycle seen, waiting for the second (hready=1)
module ahb_line_fill_master
    import ahb_pkg::*;
#(
    parameter int CACHE_LINE = 128,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_W-1:0]     mem_addr,
    output logic [CACHE_LINE-1:0] mem_data_out,
    output logic                  mem_ready,
    output logic                  mem_err,
    output logic [ADDR_W-1:0]     haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    input  logic [31:0]           hrdata,
    input  logic                  hready,
    input  logic                  hresp
);
    localparam int BEATS = CACHE_LINE / 32;

    fill_state_t state;
    htrans_t     trans_q;
    logic [2:0]  addr_cnt;      // addresses accepted in this burst, 0..4
    logic        asm_clear;
    logic        asm_capture;
    logic        asm_done;
    logic        addr_lsb_unused;

    // Once the NONSEQ has been accepted, every BURST cycle carries a data phase.
    assign asm_clear   = (state == ST_IDLE) && mem_req;
    assign asm_capture = (state == ST_BURST) && (addr_cnt != 3'd0) && hready && !hresp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            trans_q   <= HTRANS_IDLE;
            haddr     <= '0;
            addr_cnt  <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state    <= ST_BURST;
                        trans_q  <= HTRANS_NONSEQ;
                        haddr    <= {mem_addr[ADDR_W-1:4], 4'b0000};
                        addr_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if ((addr_cnt != 3'd0) && hresp) begin
                        // ERROR cancels the rest of the burst straight away.
                        trans_q <= HTRANS_IDLE;
                        if (hready) begin
                            state     <= mem_req ? ST_DONE : ST_IDLE;
                            mem_ready <= mem_req;
                            mem_err   <= mem_req;
                        end else begin
                            state <= ST_ERR;
                        end
                    end else if (hready) begin
                        if (addr_cnt != 3'd4) begin
                            addr_cnt <= addr_cnt + 3'd1;
                            if (addr_cnt == 3'd3) begin
                                trans_q <= HTRANS_IDLE;
                            end else begin
                                trans_q <= HTRANS_SEQ;
                                haddr   <= haddr + ADDR_W'(4);
                            end
                        end
                        // A withdrawn request still runs the burst out but
                        // gets no completion pulse.
                        if (asm_done) begin
                            state     <= mem_req ? ST_DONE : ST_IDLE;
                            mem_ready <= mem_req;
                        end
                    end
                end
                ST_ERR: begin
                    if (hready) begin
                        state     <= mem_req ? ST_DONE : ST_IDLE;
                        mem_ready <= mem_req;
                        mem_err   <= mem_req;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    line_assembler #(
        .CACHE_LINE (CACHE_LINE),
        .BEATS      (BEATS)
    ) u_line_assembler (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .capture (asm_capture),
        .word    (hrdata),
        .line    (mem_data_out),
        .done    (asm_done)
    );

    assign htrans = trans_q;
    assign hwrite = 1'b0;
    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_INCR4;
    assign hprot  = HPROT_IFETCH;

    // Line-offset bits are meaningless for a line-aligned fill.
    assign addr_lsb_unused = ^mem_addr[3:0];

endmodule

// File: tb/tb_ahb_line_fill_master.sv
module tb_ahb_line_fill_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req = 1'b0;
    logic [31:0]  mem_addr = '0;
    logic [127:0] mem_data_out;
    logic         mem_ready, mem_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize, hburst;
    logic [3:0]   hprot;
    logic [31:0]  hrdata = '0;
    logic         hready = 1'b1;
    logic         hresp = 1'b0;

    always #5 clk = ~clk;

    ahb_line_fill_master dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_err(mem_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hrdata(hrdata), .hready(hready),
        .hresp(hresp)
    );

    typedef struct packed {
        logic [1:0]   trans;
        logic         chk_addr;
        logic [31:0]  addr;
        logic         ready;
        logic         err;
        logic         chk_data;
        logic [127:0] data;
    } exp_t;

    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    exp_t exp_q[$];
    int   ready_cycles[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [1:0] t, input logic ca, input logic [31:0] a,
                                input logic r, input logic e, input logic cd,
                                input logic [127:0] d);
        exp_t x;
        x.trans = t; x.chk_addr = ca; x.addr = a; x.ready = r; x.err = e;
        x.chk_data = cd; x.data = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // One compare process: every cycle with a queued expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready === 1'b1) ready_cycles.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("htrans", 128'(htrans), 128'(e.trans));
                chk("mem_ready", 128'(mem_ready), 128'(e.ready));
                chk("mem_err", 128'(mem_err), 128'(e.err));
                chk("ahb_ctrl", 128'({hwrite, hsize, hburst, hprot}), 128'(11'b0_010_011_0010));
                if (e.chk_addr) chk("haddr", 128'(haddr), 128'(e.addr));
                if (e.chk_data) chk("mem_data_out", mem_data_out, e.data);
            end
        end
    end

    task automatic step(input logic r, input logic rq, input logic [31:0] ad,
                        input logic hr, input logic hs, input logic [31:0] rd,
                        input exp_t e);
        @(posedge clk);
        #1;
        rst = r; mem_req = rq; mem_addr = ad; hready = hr; hresp = hs; hrdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, $urandom,
             mk(T_IDLE, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0));
    endtask

    // Timeline of one fill built from the bus rules: sample cycle, NONSEQ,
    // then four data phases each (waits+1) long.  During data phase k the
    // address phase of beat k+1 is on the bus (IDLE after the last one).
    task automatic fill(input logic [31:0] addr, input logic [127:0] line, input int w[4],
                        input int err_beat, input int drop_beat, input int abort_beat,
                        input logic req_after, output int t0);
        logic [31:0] a;
        logic        rq;
        exp_t        idle_e, shown;
        a = {addr[31:4], 4'h0};
        rq = 1'b1;
        idle_e = mk(T_IDLE, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, addr, 1'b1, 1'b0, $urandom, idle_e);
        t0 = cyc;
        step(1'b0, rq, $urandom, 1'b1, 1'b0, $urandom, mk(T_NONSEQ, 1'b1, a, 1'b0, 1'b0, 1'b0, '0));
        for (int k = 0; k < 4; k++) begin
            shown = (k < 3) ? mk(T_SEQ, 1'b1, a + 32'(4 * (k + 1)), 1'b0, 1'b0, 1'b0, '0) : idle_e;
            if (k == abort_beat) begin
                step(1'b1, 1'b0, $urandom, 1'b1, 1'b0, $urandom, shown);
                step(1'b0, 1'b0, $urandom, 1'b1, 1'b0, $urandom,
                     mk(T_IDLE, 1'b1, '0, 1'b0, 1'b0, 1'b1, '0));
                return;
            end
            for (int j = 0; j < w[k]; j++)
                step(1'b0, rq, $urandom, 1'b0, 1'b0, $urandom, shown);
            if (k == err_beat) begin
                step(1'b0, rq, $urandom, 1'b0, 1'b1, $urandom, shown);
                step(1'b0, rq, $urandom, 1'b1, 1'b1, $urandom, idle_e);
                if (rq)
                    step(1'b0, req_after, $urandom, 1'b1, 1'b0, $urandom,
                         mk(T_IDLE, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0));
                return;
            end
            step(1'b0, rq, $urandom, 1'b1, 1'b0, line[32*k +: 32], shown);
            if (k == drop_beat && k < 3) rq = 1'b0;
        end
        if (rq)
            step(1'b0, req_after, $urandom, 1'b1, 1'b0, $urandom,
                 mk(T_IDLE, 1'b0, '0, 1'b1, 1'b0, 1'b1, line));
    endtask

    initial begin
        int w[4];
        int t0, t1;
        logic [127:0] line;

        // reset
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, mk(T_IDLE, 1'b1, '0, 1'b0, 1'b0, 1'b1, '0));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, mk(T_IDLE, 1'b1, '0, 1'b0, 1'b0, 1'b1, '0));
        idle_step();

        // zero-wait fill
        w = '{0, 0, 0, 0};
        line = 128'h00000044_00000033_00000022_00000011;
        ready_cycles.delete();
        fill(32'h0000_1234, line, w, -1, -1, -1, 1'b0, t0);
        idle_step();
        chk("zero_wait_ready_count", 128'(ready_cycles.size()), 128'(1));
        if (ready_cycles.size() > 0) chk("zero_wait_latency", 128'(ready_cycles[0] - t0), 128'(6));
        chk("zero_wait_line", mem_data_out, 128'h00000044_00000033_00000022_00000011);

        // wait states: 2 on beat 1, 1 on beat 3
        w = '{0, 2, 0, 1};
        ready_cycles.delete();
        fill(32'h0000_1234, line, w, -1, -1, -1, 1'b0, t0);
        idle_step();
        chk("wait_ready_count", 128'(ready_cycles.size()), 128'(1));
        if (ready_cycles.size() > 0) chk("wait_latency", 128'(ready_cycles[0] - t0), 128'(9));

        // two-cycle ERROR on beat 2
        w = '{0, 0, 0, 0};
        ready_cycles.delete();
        fill(32'h0000_5670, $urandom, w, 2, -1, -1, 1'b0, t0);
        idle_step();
        chk("err_ready_count", 128'(ready_cycles.size()), 128'(1));
        if (ready_cycles.size() > 0) chk("err_latency", 128'(ready_cycles[0] - t0), 128'(6));

        // request withdrawn after beat 0, then a new fill immediately
        ready_cycles.delete();
        fill(32'h0000_0800, {$urandom, $urandom, $urandom, $urandom}, w, -1, 0, -1, 1'b0, t0);
        chk("withdrawn_no_ready", 128'(ready_cycles.size()), 128'(0));
        fill(32'h0000_0040, {4{32'hA5A5_0000}}, w, -1, -1, -1, 1'b0, t0);
        idle_step();

        // reset during beat 2
        fill(32'h0000_3000, {4{32'hDEAD_BEEF}}, w, -1, -1, 2, 1'b0, t0);
        idle_step();

        // back-to-back: mem_req held across mem_ready
        ready_cycles.delete();
        fill(32'h0000_1000, {$urandom, $urandom, $urandom, $urandom}, w, -1, -1, -1, 1'b1, t0);
        fill(32'h0000_2000, {$urandom, $urandom, $urandom, $urandom}, w, -1, -1, -1, 1'b0, t1);
        idle_step();
        chk("b2b_ready_count", 128'(ready_cycles.size()), 128'(2));
        if (ready_cycles.size() > 0) chk("b2b_nonseq_gap", 128'((t1 + 1) - ready_cycles[0]), 128'(2));

        // randomized fills
        for (int n = 0; n < 40; n++) begin
            int eb, db;
            logic b2b;
            for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, 3);
            eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            db = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            b2b = ($urandom_range(0, 3) == 0);
            fill($urandom, {$urandom, $urandom, $urandom, $urandom}, w, eb, db, -1, b2b, t0);
            if (!b2b) begin
                int gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) idle_step();
            end
        end

        idle_step();
        idle_step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
